// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch controller.
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam logic [31:0]  INSTR_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam int unsigned  PC_INCR          = 4;

endpackage

// File: rtl/prefetch_ctrl.sv
// Instruction prefetch controller: issues OBI fetches, feeds the instruction FIFO,
// tags popped words with their PC. Optional perf counters: PREFETCH_PERF_CNT_EN.
module prefetch_ctrl
  import prefetch_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned FIFO_SIZE       = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fetch_en_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  output logic            fifo_flush_o,
  output logic            fifo_push_o,
  output logic [XLEN-1:0] fifo_wdata_o,
  output logic            fifo_pop_o,
  input  logic            pop_req_i,
  output logic            out_valid_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [31:0]     perf_stall_o,
  output logic [31:0]     perf_discard_o
);

  localparam int unsigned CW = $clog2(FIFO_SIZE + 1);
  localparam int unsigned SW = CW + 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] redir_addr_q, redir_addr_d;
  logic            redir_pend_q, redir_pend_d;
  logic [XLEN-1:0] pop_pc_q, pop_pc_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   disc_q, disc_d;

  logic            req_pending_c;
  logic            gnt_acc_c;
  logic            drop_rsp_c;
  logic            push_c;
  logic            pop_c;
  logic            credit_ok_c;
  logic [SW-1:0]   credit_sum_c;
  logic [XLEN-1:0] redirect_pc_c;

  always_comb begin
    req_pending_c = (state_q == RUN);
    gnt_acc_c     = req_pending_c & instr_gnt_i;
    drop_rsp_c    = instr_rvalid_i & (disc_q != '0);
    push_c        = instr_rvalid_i & (disc_q == '0) & ~redirect_i;
    // FIFO forwards data_i on push+pop, so pairing them is only legal when empty
    pop_c         = pop_req_i & ~redirect_i &
                    (((occ_q != '0) & ~push_c) | ((occ_q == '0) & push_c));
    redirect_pc_c = redirect_addr_i & ~XLEN'(~INSTR_ALIGN_MASK);
  end

  // Counters: occupancy, in-flight requests, responses still to be thrown away
  always_comb begin
    outst_d = outst_q + CW'(gnt_acc_c) - CW'(instr_rvalid_i);

    occ_d = occ_q;
    if (redirect_i)            occ_d = '0;
    else if (push_c && !pop_c) occ_d = occ_q + CW'(1);
    else if (pop_c && !push_c) occ_d = occ_q - CW'(1);

    if (redirect_i) disc_d = outst_d;
    else            disc_d = disc_q + CW'(gnt_acc_c & redir_pend_q) - CW'(drop_rsp_c);

    credit_sum_c = SW'(occ_d) + SW'(outst_d);
    credit_ok_c  = (credit_sum_c < SW'(FIFO_SIZE)) && (outst_d < CW'(MAX_OUTSTANDING));
  end

  // Fetch and pop address tracking; an ungranted request keeps its address
  always_comb begin
    req_addr_d   = req_addr_q;
    redir_addr_d = redir_addr_q;
    redir_pend_d = redir_pend_q;
    pop_pc_d     = pop_pc_q;
    out_pc_d     = out_pc_q;
    out_valid_d  = pop_c;

    if (redirect_i) redir_addr_d = redirect_pc_c;

    if (redirect_i && req_pending_c && !instr_gnt_i) begin
      redir_pend_d = 1'b1;
    end else if (redirect_i) begin
      req_addr_d   = redirect_pc_c;
      redir_pend_d = 1'b0;
    end else if (gnt_acc_c) begin
      req_addr_d   = redir_pend_q ? redir_addr_q : req_addr_q + XLEN'(PC_INCR);
      redir_pend_d = 1'b0;
    end

    if (redirect_i) pop_pc_d = redirect_pc_c;
    else if (pop_c) pop_pc_d = pop_pc_q + XLEN'(PC_INCR);

    if (pop_c) out_pc_d = pop_pc_q;
  end

  // Request FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_en_i && credit_ok_c && !redirect_i) state_d = RUN;
      end
      RUN: begin
        if (instr_gnt_i) begin
          if (!credit_ok_c)     state_d = STALL;
          else if (!fetch_en_i) state_d = IDLE;
        end
      end
      STALL: begin
        if (!fetch_en_i)      state_d = IDLE;
        else if (credit_ok_c) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      redir_addr_q <= '0;
      redir_pend_q <= 1'b0;
      pop_pc_q     <= '0;
      out_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      occ_q        <= '0;
      outst_q      <= '0;
      disc_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      redir_addr_q <= redir_addr_d;
      redir_pend_q <= redir_pend_d;
      pop_pc_q     <= pop_pc_d;
      out_pc_q     <= out_pc_d;
      out_valid_q  <= out_valid_d;
      occ_q        <= occ_d;
      outst_q      <= outst_d;
      disc_q       <= disc_d;
    end
  end

  assign instr_req_o  = (state_q == RUN);
  assign instr_addr_o = req_addr_q;
  assign fifo_flush_o = redirect_i;
  assign fifo_push_o  = push_c;
  assign fifo_wdata_o = instr_rdata_i;
  assign fifo_pop_o   = pop_c;
  assign out_valid_o  = out_valid_q;
  assign out_pc_o     = out_pc_q;

`ifdef PREFETCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_disc_q, perf_disc_d;

  // Saturating event counters, cleared only by reset
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_disc_d  = perf_disc_q;
    if ((state_q == STALL) && fetch_en_i && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    if (drop_rsp_c && (perf_disc_q != '1))                          perf_disc_d  = perf_disc_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_disc_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_disc_q  <= perf_disc_d;
    end
  end

  assign perf_stall_o   = perf_stall_q;
  assign perf_discard_o = perf_disc_q;
`else
  assign perf_stall_o   = '0;
  assign perf_discard_o = '0;
`endif

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Self-checking bench for prefetch_ctrl with a behavioural FIFO and memory responder.
module tb_prefetch_ctrl;

  localparam int unsigned FIFO_SIZE = 4;
  localparam int unsigned MAX_OUT   = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_en, redirect, gnt, rvalid, pop_req;
  logic [31:0] redirect_addr, rdata;
  logic        instr_req, fifo_flush, fifo_push, fifo_pop, out_valid;
  logic [31:0] instr_addr, fifo_wdata, out_pc, perf_stall, perf_discard;

  always #5 clk_i = ~clk_i;

  prefetch_ctrl #(.XLEN(32), .FIFO_SIZE(FIFO_SIZE), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .fetch_en_i      (fetch_en),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .instr_req_o     (instr_req),
    .instr_addr_o    (instr_addr),
    .instr_gnt_i     (gnt),
    .instr_rvalid_i  (rvalid),
    .instr_rdata_i   (rdata),
    .fifo_flush_o    (fifo_flush),
    .fifo_push_o     (fifo_push),
    .fifo_wdata_o    (fifo_wdata),
    .fifo_pop_o      (fifo_pop),
    .pop_req_i       (pop_req),
    .out_valid_o     (out_valid),
    .out_pc_o        (out_pc),
    .perf_stall_o    (perf_stall),
    .perf_discard_o  (perf_discard)
  );

  // Behavioural instruction FIFO as the parent would attach it
  logic [31:0] fmem [FIFO_SIZE];
  int unsigned f_cnt, f_rd, f_wr;
  logic [31:0] f_dout;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_cnt <= 0; f_rd <= 0; f_wr <= 0; f_dout <= '0;
    end else if (fifo_flush) begin
      f_cnt <= 0; f_rd <= 0; f_wr <= 0;
    end else begin
      if (fifo_push && !(fifo_pop && f_cnt == 0)) begin
        fmem[f_wr] <= fifo_wdata;
        f_wr <= (f_wr + 1) % FIFO_SIZE;
      end
      if (fifo_pop) begin
        if (f_cnt == 0) f_dout <= fifo_wdata;
        else begin
          f_dout <= fmem[f_rd];
          f_rd <= (f_rd + 1) % FIFO_SIZE;
        end
      end
      if (fifo_push && !fifo_pop) f_cnt <= f_cnt + 1;
      else if (fifo_pop && !fifo_push && f_cnt > 0) f_cnt <= f_cnt - 1;
    end
  end

  typedef struct { logic [31:0] addr; int unsigned tag; int unsigned ready; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t        rsp_q [$];
  ent_t        sb_q  [$];
  ent_t        out_exp;
  logic        exp_valid;
  int          n_cmp, n_bad;
  int unsigned cyc, epoch, cur_tag, grant_cnt, drop_cnt;
  logic        held_prev;
  logic [31:0] held_addr, exp_addr;

  logic        s_fetch_en, s_redirect, s_gnt_en, s_rv_en, s_pop_req;
  logic [31:0] s_redirect_addr;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  // Scoreboard: tags each grant with the redirect epoch it was issued in
  task automatic monitor();
    req_t e;
    logic exp_push, exp_pop;
    int unsigned occ;
    n_cmp++;
    if (out_valid !== exp_valid) begin
      n_bad++; $display("FAIL out_valid: got %b expected %b (cyc %0d)", out_valid, exp_valid, cyc);
    end
    if (exp_valid) begin
      n_cmp++;
      if (out_pc !== out_exp.pc || f_dout !== out_exp.data) begin
        n_bad++;
        $display("FAIL out_word: got pc %h data %h expected pc %h data %h", out_pc, f_dout, out_exp.pc, out_exp.data);
      end
    end
    exp_push = 1'b0;
    e = '{addr: 32'h0, tag: 0, ready: 0};
    if (rvalid) begin
      e = rsp_q.pop_front();
      exp_push = (e.tag == epoch) && !redirect;
      if (!exp_push) drop_cnt++;
    end
    n_cmp++;
    if (fifo_push !== exp_push) begin
      n_bad++; $display("FAIL push: got %b expected %b (cyc %0d)", fifo_push, exp_push, cyc);
    end
    n_cmp++;
    if (fifo_flush !== redirect) begin
      n_bad++; $display("FAIL flush: got %b expected %b", fifo_flush, redirect);
    end
    if (instr_req) begin
      if (held_prev) begin
        n_cmp++;
        if (instr_addr !== held_addr) begin
          n_bad++; $display("FAIL addr_hold: got %h expected %h", instr_addr, held_addr);
        end
      end else cur_tag = epoch;
    end
    if (instr_req && gnt) begin
      if (cur_tag == epoch) begin
        n_cmp++;
        if (instr_addr !== exp_addr) begin
          n_bad++; $display("FAIL req_addr: got %h expected %h", instr_addr, exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
      end
      rsp_q.push_back('{addr: instr_addr, tag: cur_tag, ready: cyc + 1});
      grant_cnt++;
      n_cmp++;
      if (rsp_q.size() > MAX_OUT) begin
        n_bad++; $display("FAIL outstanding: got %0d expected <= %0d", rsp_q.size(), MAX_OUT);
      end
    end
    held_prev = instr_req && !gnt;
    held_addr = instr_addr;
    occ = sb_q.size();
    exp_pop = pop_req && !redirect && ((occ > 0 && !exp_push) || (occ == 0 && exp_push));
    n_cmp++;
    if (fifo_pop !== exp_pop) begin
      n_bad++; $display("FAIL pop: got %b expected %b (cyc %0d)", fifo_pop, exp_pop, cyc);
    end
    n_cmp++;
    if ((fifo_push && !fifo_pop && f_cnt >= FIFO_SIZE) || (fifo_pop && !fifo_push && f_cnt == 0)) begin
      n_bad++; $display("FAIL fifo_bounds: got cnt %0d push %b pop %b expected no over/underflow", f_cnt, fifo_push, fifo_pop);
    end
    if (exp_push) sb_q.push_back('{pc: e.addr, data: data_of(e.addr)});
    exp_valid = 1'b0;
    if (exp_pop && sb_q.size() > 0) begin
      out_exp = sb_q.pop_front();
      exp_valid = 1'b1;
    end
    if (redirect) begin
      sb_q.delete();
      epoch++;
      exp_addr = redirect_addr & 32'hFFFF_FFFC;
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      fetch_en      = s_fetch_en;
      pop_req       = s_pop_req;
      redirect      = s_redirect;
      redirect_addr = s_redirect_addr;
      s_redirect    = 1'b0;
      gnt           = s_gnt_en & instr_req;
      if (s_rv_en && rsp_q.size() > 0 && rsp_q[0].ready <= cyc) begin
        rvalid = 1'b1; rdata = data_of(rsp_q[0].addr);
      end else begin
        rvalid = 1'b0; rdata = '0;
      end
      #1;
      monitor();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    s_fetch_en = 0; s_redirect = 0; s_gnt_en = 1; s_rv_en = 1; s_pop_req = 0; s_redirect_addr = '0;
    rsp_q.delete(); sb_q.delete();
    exp_valid = 0; epoch = 0; cur_tag = 0; held_prev = 0; held_addr = '0; exp_addr = '0;
    step(2);
    n_cmp++;
    if ({instr_req, fifo_flush, fifo_push, fifo_pop, out_valid} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {instr_req, fifo_flush, fifo_push, fifo_pop, out_valid});
    end
    n_cmp++;
    if (instr_addr !== 32'h0 || out_pc !== 32'h0) begin
      n_bad++; $display("FAIL reset_addr: got addr %h pc %h expected 0", instr_addr, out_pc);
    end
    n_cmp++;
    if (perf_stall !== 32'h0 || perf_discard !== 32'h0) begin
      n_bad++; $display("FAIL reset_perf: got %h %h expected 0", perf_stall, perf_discard);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_fill();
    grant_cnt = 0;
    s_fetch_en = 1; s_gnt_en = 1; s_rv_en = 1; s_pop_req = 0;
    step(10);
    n_cmp++;
    if (grant_cnt != 4) begin
      n_bad++; $display("FAIL fill_grants: got %0d expected 4", grant_cnt);
    end
    n_cmp++;
    if (instr_req !== 1'b0 || f_cnt != 4) begin
      n_bad++; $display("FAIL fill_stall: got req %b occ %0d expected req 0 occ 4", instr_req, f_cnt);
    end
  endtask

  task automatic test_drain();
    int unsigned g0;
    g0 = grant_cnt;
    s_pop_req = 1;
    step(1);
    n_cmp++;
    if (fifo_pop !== 1'b1) begin
      n_bad++; $display("FAIL drain_first_pop: got %b expected 1", fifo_pop);
    end
    step(1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_bad++; $display("FAIL drain_first_out: got %b pc %h expected 1 pc 00000000", out_valid, out_pc);
    end
    step(10);
    n_cmp++;
    if (grant_cnt <= g0) begin
      n_bad++; $display("FAIL drain_resume: got %0d grants expected > %0d", grant_cnt, g0);
    end
    s_fetch_en = 0;
    step(14);
    n_cmp++;
    if (f_cnt != 0 || rsp_q.size() != 0 || instr_req !== 1'b0) begin
      n_bad++; $display("FAIL drain_empty: got occ %0d outst %0d req %b expected 0 0 0", f_cnt, rsp_q.size(), instr_req);
    end
    s_pop_req = 0;
    step(2);
  endtask

  task automatic test_bypass();
    s_fetch_en = 1; step(1);
    s_fetch_en = 0; step(1);
    s_pop_req = 1; step(1);
    n_cmp++;
    if (!(rvalid && fifo_push && fifo_pop)) begin
      n_bad++; $display("FAIL bypass_same_cycle: got rvalid %b push %b pop %b expected 111", rvalid, fifo_push, fifo_pop);
    end
    s_pop_req = 0; step(1);
    n_cmp++;
    if (out_valid !== 1'b1 || f_cnt != 0) begin
      n_bad++; $display("FAIL bypass_out: got valid %b occ %0d expected 1 0", out_valid, f_cnt);
    end
    step(2);
  endtask

  task automatic test_defer();
    s_fetch_en = 1; step(3);
    s_fetch_en = 0; step(1);
    s_pop_req = 1; step(1);
    n_cmp++;
    if (!(rvalid && fifo_push && !fifo_pop)) begin
      n_bad++; $display("FAIL defer_push_only: got rvalid %b push %b pop %b expected 110", rvalid, fifo_push, fifo_pop);
    end
    step(1);
    n_cmp++;
    if (fifo_pop !== 1'b1) begin
      n_bad++; $display("FAIL defer_pop_next: got %b expected 1", fifo_pop);
    end
    step(4);
    s_pop_req = 0; step(2);
    n_cmp++;
    if (f_cnt != 0) begin
      n_bad++; $display("FAIL defer_empty: got occ %0d expected 0", f_cnt);
    end
  endtask

  task automatic test_redirect_outstanding();
    int unsigned d0;
    d0 = drop_cnt;
    s_rv_en = 0; s_fetch_en = 1; s_gnt_en = 1; s_pop_req = 0;
    step(3);
    n_cmp++;
    if (rsp_q.size() != 2) begin
      n_bad++; $display("FAIL redir_two_outst: got %0d expected 2", rsp_q.size());
    end
    s_redirect = 1; s_redirect_addr = 32'h0000_1006;
    step(1);
    n_cmp++;
    if (fifo_flush !== 1'b1 || instr_req !== 1'b0) begin
      n_bad++; $display("FAIL redir_flush: got flush %b req %b expected 1 0", fifo_flush, instr_req);
    end
    s_rv_en = 1;
    step(1);
    n_cmp++;
    if (!(rvalid && !fifo_push)) begin
      n_bad++; $display("FAIL redir_drop1: got rvalid %b push %b expected 1 0", rvalid, fifo_push);
    end
    step(1);
    n_cmp++;
    if (!(rvalid && !fifo_push) || instr_req !== 1'b1 || instr_addr !== 32'h0000_1004) begin
      n_bad++; $display("FAIL redir_drop2_newreq: got push %b req %b addr %h expected 0 1 00001004", fifo_push, instr_req, instr_addr);
    end
    n_cmp++;
    if (drop_cnt - d0 != 2) begin
      n_bad++; $display("FAIL redir_drop_count: got %0d expected 2", drop_cnt - d0);
    end
`ifdef PREFETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_discard !== 32'd2) begin
      n_bad++; $display("FAIL perf_discard: got %0d expected 2", perf_discard);
    end
`endif
    s_fetch_en = 0; s_pop_req = 1;
    step(10);
    s_pop_req = 0; step(2);
  endtask

  task automatic test_redirect_pending();
    logic [31:0] x;
    s_gnt_en = 0; s_fetch_en = 1; s_rv_en = 1; s_pop_req = 0;
    step(1);
    x = exp_addr;
    s_redirect = 1; s_redirect_addr = 32'h0000_2000;
    step(1);
    n_cmp++;
    if (instr_req !== 1'b1 || instr_addr !== x || gnt !== 1'b0) begin
      n_bad++; $display("FAIL pend_req: got req %b addr %h expected 1 %h", instr_req, instr_addr, x);
    end
    step(1);
    n_cmp++;
    if (instr_addr !== x) begin
      n_bad++; $display("FAIL pend_hold: got %h expected %h", instr_addr, x);
    end
    s_gnt_en = 1;
    step(1);
    n_cmp++;
    if (instr_addr !== x || gnt !== 1'b1) begin
      n_bad++; $display("FAIL pend_gnt_old: got %h expected %h", instr_addr, x);
    end
    step(1);
    n_cmp++;
    if (!(rvalid && !fifo_push) || instr_addr !== 32'h0000_2000) begin
      n_bad++; $display("FAIL pend_discard_next: got push %b addr %h expected 0 00002000", fifo_push, instr_addr);
    end
    s_fetch_en = 0; s_pop_req = 1;
    step(10);
    s_pop_req = 0; step(2);
    n_cmp++;
    if (f_cnt != 0 || rsp_q.size() != 0 || sb_q.size() != 0) begin
      n_bad++; $display("FAIL final_idle: got occ %0d outst %0d sb %0d expected 0", f_cnt, rsp_q.size(), sb_q.size());
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; grant_cnt = 0; drop_cnt = 0;
    fetch_en = 0; redirect = 0; redirect_addr = '0; gnt = 0; rvalid = 0; rdata = '0; pop_req = 0;
    test_reset();
    test_fill();
    test_drain();
    test_bypass();
    test_defer();
    test_redirect_outstanding();
    test_redirect_pending();
`ifdef PREFETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_discard !== 32'd3) begin
      n_bad++; $display("FAIL perf_discard_total: got %0d expected 3", perf_discard);
    end
`else
    n_cmp++;
    if (perf_stall !== 32'h0 || perf_discard !== 32'h0) begin
      n_bad++; $display("FAIL perf_tied_off: got %h %h expected 0", perf_stall, perf_discard);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prefetch_ctrl.md
Name: prefetch_ctrl

Overview:
Instruction prefetch controller that sequences the 32-bit instruction FIFO (fifo, FIFO_SIZE entries, push/pop/flush, registered data_o).
- Issues word-aligned fetches on an OBI-style req/gnt/rvalid instruction port.
- Pushes returned words into the FIFO.
- Pops words on behalf of the decode stage and tags each with its PC.
- Handles branch redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
XLEN, 32, instruction/address width.
FIFO_SIZE, 4, depth of the attached FIFO; power of two, >=2.
MAX_OUTSTANDING, 2, max granted-but-unreturned requests; 1..FIFO_SIZE.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
fetch_en_i  in  1  enables issuing new requests.
redirect_i  in  1  single-cycle branch/exception redirect.
redirect_addr_i  in  XLEN  new fetch PC.
instr_req_o  out  1  memory request.
instr_addr_o  out  XLEN  request address, bits [1:0]=0.
instr_gnt_i  in  1  request accepted.
instr_rvalid_i  in  1  response valid, in order, one per grant.
instr_rdata_i  in  XLEN  response data.
fifo_flush_o  out  1  to FIFO flush_en_i.
fifo_push_o  out  1  to FIFO push_en_i.
fifo_wdata_o  out  XLEN  to FIFO data_i (= instr_rdata_i).
fifo_pop_o  out  1  to FIFO pop_en_i.
pop_req_i  in  1  decode requests next instruction word.
out_valid_o  out  1  FIFO data_o holds a valid word this cycle.
out_pc_o  out  XLEN  PC of that word.
perf_stall_o  out  32  credit-stall cycle count (optional feature).
perf_discard_o  out  32  discarded response count (optional feature).

Behaviour:
Reset:
- Outputs are 0; req_addr = 0; occupancy cnt = 0, outstanding cnt = 0, discard cnt = 0.
- State IDLE. Reset mid-transaction drops all tracking; responses returning after reset are ignored (discard cnt is 0, so the bench must not drive them).

Credits:
- A new request is allowed only when occ + outstanding + req_pending < FIFO_SIZE and outstanding < MAX_OUTSTANDING.
- occ counts entries in the FIFO: +1 on push, -1 on pop, 0 on push+pop.

FSM:
- IDLE: instr_req_o=0. Goes to RUN when fetch_en_i=1 and credits are available.
- RUN: instr_req_o=1 with instr_addr_o=req_addr, held stable until gnt.
  - On gnt: req_addr += 4; outstanding +1. Goes to STALL if credits are exhausted after this grant, to IDLE if fetch_en_i=0, else stays in RUN (back-to-back requests).
- STALL: instr_req_o=0. Returns to RUN when credits free up, or to IDLE when fetch_en_i=0.
- Dropping fetch_en_i while req is pending without gnt does not retract req; it is held until gnt, then the FSM goes to IDLE.

Response:
- On rvalid with discard cnt > 0: discard cnt -1, outstanding -1, no push.
- On rvalid with discard cnt = 0: fifo_push_o=1 the same cycle, outstanding -1.

Pop/push ordering:
- The FIFO forwards data_i on simultaneous push+pop. Push+pop together is therefore permitted only when occ=0 (bypass).
- When occ>0 and a push occurs, pop is deferred and pop_req_i is not honoured that cycle.
- fifo_pop_o = pop_req_i & ~redirect_i & ((occ>0 & ~push) | (occ=0 & push)).

Output:
- out_valid_o is registered: 1 in the cycle after fifo_pop_o, else 0.
- out_pc_o = pop_pc latched at pop; pop_pc += 4 per pop.

Redirect (highest priority, overrides all same-cycle events):
- fifo_flush_o=1 combinationally; no push or pop that cycle; occ=0.
- discard cnt = outstanding + (req pending & gnt this cycle) - (rvalid this cycle).
- req_addr and pop_pc = {redirect_addr_i[XLEN-1:2], 2'b00}; out_valid_o=0 next cycle.
- A pending ungranted request keeps its old address until gnt, counts as discard, and the new fetch issues afterwards.
- Redirect in IDLE only reloads the addresses.

Widths:
- Counters are $clog2(FIFO_SIZE+1) bits and must never over- or underflow; the bench asserts this.

Optional Feature:
PREFETCH_PERF_CNT_EN:
- Defined: perf_stall_o counts cycles in STALL with fetch_en_i=1; perf_discard_o counts discarded responses. Both are 32-bit, saturating, and cleared only by reset.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Package prefetch_pkg holds the FSM state enum (IDLE, RUN, STALL) and the INSTR_ALIGN_MASK and PC_INCR constants.
- No sub-module: the credit/discard counters and FSM live in one module. The FIFO is instantiated by the parent alongside this block.

Test Plan:
1. Reset, fetch_en=1, gnt always 1, rvalid 1 cycle later, pop_req=0 -> requests at 0x0,0x4,0x8,0xC, then STALL with occ=4; no fifth request.
2. With the FIFO full (occ=4), pop_req=1 each cycle -> out_valid with out_pc 0x0,0x4,... one cycle after each pop; requests resume as credits free up.
3. occ=0, rvalid and pop_req in the same cycle -> push+pop bypass; out_valid=1 next cycle with that word; occ stays 0.
4. occ=2, rvalid and pop_req in the same cycle -> push only, pop deferred one cycle; word order preserved.
5. Two outstanding requests, redirect to 0x1006 -> flush; the next 2 rvalids are dropped (perf_discard=2 with the macro); the first new request is at 0x1004.
6. Redirect while req is pending without gnt, gnt 2 cycles later -> old address held until gnt; that response is discarded; the next request goes to the redirect address.
